// File: rtl/mul_div_unit_if.sv
// Issue-side and CDB-side signal bundle for mul_div_unit.
// The reservation station/CDB side uses the master modport and the unit uses the slave modport.
interface mul_div_unit_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 3
);
   // Both handshakes use strict valid/ready. A transfer happens only on a rising edge
   // where valid and ready are both 1. Valid may not depend on ready. The source holds
   // payload stable while valid is high and the transfer has not happened yet.
   logic             issue_valid;
   logic             issue_ready;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic [2:0]       fun3;
   logic [TAG_W-1:0] des;
   logic             cdb_valid;
   logic             cdb_ready;
   logic [WIDTH-1:0] cdb_data;
   logic [TAG_W-1:0] cdb_tag;
   logic             busy;

   modport master (
      output issue_valid, data1, data2, fun3, des, cdb_ready,
      input  issue_ready, cdb_valid, cdb_data, cdb_tag, busy
   );

   modport slave (
      input  issue_valid, data1, data2, fun3, des, cdb_ready,
      output issue_ready, cdb_valid, cdb_data, cdb_tag, busy
   );
endinterface

// File: rtl/mul_div_unit.sv
// Unsigned multiply/divide unit: MUL/MULHU, DIVU/REMU, with results broadcast on the CDB.
// Define MULDIV_FLUSH_EN to add a flush input that aborts an in-flight op without a broadcast.
module mul_div_unit #(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 3,
   parameter int MUL_LAT = 4
) (
   input  logic               clk1,
   input  logic               rst_n,
`ifdef MULDIV_FLUSH_EN
   input  logic               flush,
`endif
   mul_div_unit_if.slave      bus,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // One counter serves both the multiply delay line and the divider bit count.
   localparam int CNT_W = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state;
   state_t             state_d;
   logic               accept;
   logic               ready;
   logic               abort;

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [TAG_W-1:0]   tag_q;
   logic               hi_sel;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   res_q;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_nx;
   logic               div_zero;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;

`ifdef MULDIV_FLUSH_EN
   assign abort = flush;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      ready   = 1'b0;
      case (state)
         IDLE: begin
            // No op is taken in a flush cycle, even while idle.
            ready = !abort;
            if (bus.issue_valid && ready) begin
               accept = 1'b1;
               case (bus.fun3)
                  3'b000, 3'b011: state_d = MUL;
                  3'b001, 3'b010: state_d = DIV;
                  default:        state_d = DONE;
               endcase
            end
         end
         MUL: begin
            if (cnt == '0) state_d = DONE;
         end
         DIV: begin
            if (cnt == '0) state_d = DONE;
         end
         DONE: begin
            if (bus.cdb_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Restoring step: shift the next dividend bit into the partial remainder and subtract
   // if it fits. The borrow bit of the (WIDTH+1)-bit difference is the compare result.
   assign div_trial = {rem_q, quo_q[WIDTH-1]};
   assign div_diff  = div_trial - {1'b0, b_q};
   assign div_ge    = ~div_diff[WIDTH];
   assign rem_nx    = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

   // A zero divisor is overridden explicitly. The raw iteration can overflow the borrow test.
   assign div_zero  = (b_q == '0);
   assign div_quo   = div_zero ? {WIDTH{1'b1}} : quo_q;
   assign div_rem   = div_zero ? a_q : rem_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         tag_q  <= '0;
         hi_sel <= 1'b0;
         cnt    <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         res_q  <= '0;
      end else if (accept) begin
         a_q    <= bus.data1;
         b_q    <= bus.data2;
         tag_q  <= bus.des;
         // fun3[1] picks the high product half for MULHU and the remainder for REMU.
         hi_sel <= bus.fun3[1];
         quo_q  <= bus.data1;
         rem_q  <= '0;
         case (state_d)
            MUL: cnt <= MUL_LOAD;
            DIV: cnt <= DIV_LOAD;
            default: begin
               cnt   <= '0;
               res_q <= '0;
            end
         endcase
      end else if (!abort) begin
         case (state)
            MUL: begin
               if (cnt == '0) begin
                  res_q <= hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            DIV: begin
               if (cnt != '0) begin
                  rem_q <= rem_nx;
                  quo_q <= {quo_q[WIDTH-2:0], div_ge};
                  cnt   <= cnt - CNT_ONE;
               end else begin
                  res_q <= hi_sel ? div_rem : div_quo;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.issue_ready = ready;
   assign bus.busy        = (state != IDLE);
   assign bus.cdb_valid   = (state == DONE);
   assign bus.cdb_data    = res_q;
   assign bus.cdb_tag     = tag_q;
   assign dbg_state       = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference model.
// Build with MULDIV_FLUSH_EN defined to also exercise the flush abort.
module tb_mul_div_unit;
  localparam int WIDTH   = 32;
  localparam int TAG_W   = 3;
  localparam int MUL_LAT = 4;

  logic             clk1;
  logic             rst_n;
  logic             flush;
  logic [1:0]       dbg_state;
  int               n_tests;
  int               n_fail;

  mul_div_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  mul_div_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
`ifdef MULDIV_FLUSH_EN
    .flush     (flush),
`endif
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: plain unsigned arithmetic
  function automatic logic [WIDTH-1:0] model_result(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                    logic [2:0] f);
    logic [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    case (f)
      3'b000:  return p[WIDTH-1:0];
      3'b011:  return p[2*WIDTH-1:WIDTH];
      3'b001:  return (b == 0) ? {WIDTH{1'b1}} : a / b;
      3'b010:  return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // rising edges after the accept edge before cdb_valid is seen; illegal ops go
  // straight to the broadcast state, so their result is visible in the next cycle
  function automatic int model_latency(logic [2:0] f);
    case (f)
      3'b000, 3'b011: return MUL_LAT;
      3'b001, 3'b010: return WIDTH + 1;
      default:        return 0;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    bus.issue_valid = 1'($urandom_range(0, 1));
    bus.data1       = $urandom();
    bus.data2       = $urandom();
    bus.fun3        = 3'($urandom());
    bus.des         = TAG_W'($urandom());
  endtask

  task automatic issue_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] f, input logic [TAG_W-1:0] d);
    int waited;
    waited = 0;
    while (!bus.issue_ready && waited < 10) begin
      tick();
      waited++;
    end
    check("issue_ready_wait", 64'(bus.issue_ready), 64'(1));
    bus.data1       = a;
    bus.data2       = b;
    bus.fun3        = f;
    bus.des         = d;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    check("accept_busy", 64'(bus.busy), 64'(1));
    check("accept_not_ready", 64'(bus.issue_ready), 64'(0));
  endtask

  task automatic wait_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [2:0] f, input logic [TAG_W-1:0] d, input int hold);
    int lat;
    logic [WIDTH-1:0] exp_d;
    exp_d = model_result(a, b, f);
    lat = 0;
    bus.cdb_ready = (hold == 0);
    while (!bus.cdb_valid && lat < 100) begin
      noise();
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(model_latency(f)));
    check("cdb_data", 64'(bus.cdb_data), 64'(exp_d));
    check("cdb_tag", 64'(bus.cdb_tag), 64'(d));
    for (int i = 0; i < hold; i++) begin
      noise();
      tick();
      check("hold_valid", 64'(bus.cdb_valid), 64'(1));
      check("hold_data", 64'(bus.cdb_data), 64'(exp_d));
      check("hold_tag", 64'(bus.cdb_tag), 64'(d));
      check("hold_not_ready", 64'(bus.issue_ready), 64'(0));
    end
    // an op offered in the draining cycle must not be taken
    bus.cdb_ready   = 1'b1;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    bus.cdb_ready   = 1'b0;
    check("drain_busy", 64'(bus.busy), 64'(0));
    check("drain_ready", 64'(bus.issue_ready), 64'(1));
    check("drain_valid", 64'(bus.cdb_valid), 64'(0));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] f, input logic [TAG_W-1:0] d, input int hold);
    issue_op(a, b, f, d);
    wait_result(a, b, f, d, hold);
  endtask

  // directed sequence followed by random ops
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       rf;
    logic [TAG_W-1:0] rd;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.fun3  = '0;
    bus.des   = '0;
    bus.cdb_ready = 1'b0;
    #2;
    check("rst_ready", 64'(bus.issue_ready), 64'(1));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_valid", 64'(bus.cdb_valid), 64'(0));
    check("rst_data", 64'(bus.cdb_data), 64'(0));
    check("rst_tag", 64'(bus.cdb_tag), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op(32'd6, 32'd7, 3'b000, 3'd5, 0);
    run_op(32'd100, 32'd7, 3'b001, 3'd2, 0);
    run_op(32'd100, 32'd7, 3'b010, 3'd2, 1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 3'd7, 0);
    run_op(32'd12345, 32'd0, 3'b001, 3'd1, 2);
    run_op(32'd12345, 32'd0, 3'b010, 3'd4, 0);
    run_op(32'hDEAD_BEEF, 32'd3, 3'b101, 3'd6, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b001, 3'd3, 0);
    run_op(32'd5, 32'd9, 3'b010, 3'd0, 0);
    run_op(32'd1234, 32'd5678, 3'b000, 3'd6, 10);

    // reset in the middle of a divide
    issue_op(32'd1000, 32'd3, 3'b001, 3'd3);
    bus.cdb_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("pre_rst_valid", 64'(bus.cdb_valid), 64'(0));
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.issue_ready), 64'(1));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_valid", 64'(bus.cdb_valid), 64'(0));
    check("mid_rst_data", 64'(bus.cdb_data), 64'(0));
    check("mid_rst_tag", 64'(bus.cdb_tag), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("in_rst_valid", 64'(bus.cdb_valid), 64'(0));
    end
    bus.cdb_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    run_op(32'd11, 32'd13, 3'b000, 3'd2, 0);

`ifdef MULDIV_FLUSH_EN
    issue_op(32'd9, 32'd9, 3'b000, 3'd4);
    tick();
    flush = 1'b1;
    bus.issue_valid = 1'b1;
    bus.fun3 = 3'b000;
    tick();
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_ready", 64'(bus.issue_ready), 64'(1));
    bus.cdb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flush_no_valid", 64'(bus.cdb_valid), 64'(0));
      check("flush_idle", 64'(bus.busy), 64'(0));
    end
    bus.cdb_ready = 1'b0;
    run_op(32'd21, 32'd2, 3'b000, 3'd1, 0);
`endif

    for (int n = 0; n < 16; n++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = WIDTH'($urandom_range(1, 20));
        default: rb = $urandom();
      endcase
      rf = 3'($urandom_range(0, 7));
      rd = TAG_W'($urandom());
      run_op(ra, rb, rf, rd, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 The module SHALL have parameter TAG_W, default 3, ROB destination tag width.
REQ-003 The module SHALL have parameter MUL_LAT, default 4, accept-to-result cycles for multiply ops (legal range 1..15).
REQ-004 The module SHALL have the port clk1, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have the port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have the port issue_valid, input, 1, reservation station presents an op.
REQ-007 The module SHALL have the port issue_ready, output, 1, the unit can accept an op this cycle.
REQ-008 The module SHALL have the ports data1 and data2, input, WIDTH each, unsigned operands.
REQ-009 The module SHALL have the port fun3, input, 3, op select: 000 MUL low, 001 DIVU, 010 REMU, 011 MULHU.
REQ-010 The module SHALL have the port des, input, TAG_W, ROB tag of the op.
REQ-011 The module SHALL have the port cdb_valid, output, 1, result broadcast request.
REQ-012 The module SHALL have the port cdb_ready, input, 1, CDB grant.
REQ-013 The module SHALL have the ports cdb_data (WIDTH) and cdb_tag (TAG_W), output, result and its ROB tag.
REQ-014 The module SHALL have the port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 An op SHALL be accepted on a rising edge where issue_valid and issue_ready are both 1; operands, fun3 and des are latched at that edge.
REQ-016 issue_ready SHALL be 1 only in IDLE; no new op is accepted in MUL, DIV or DONE, including the cycle DONE drains.
REQ-017 FSM states SHALL be IDLE, MUL, DIV, DONE; transitions: IDLE->MUL on accept with fun3 000/011; IDLE->DIV on accept with 001/010; IDLE->DONE on accept with any other fun3.
REQ-018 MUL SHALL form the full 2*WIDTH product; cdb_valid SHALL rise exactly MUL_LAT cycles after the accept edge; result is low half (000) or high half (011).
REQ-019 DIV SHALL be a restoring divider producing one quotient bit per cycle; cdb_valid SHALL rise exactly WIDTH+1 cycles after the accept edge; result is quotient (001) or remainder (010).
REQ-020 Divide by zero SHALL yield quotient all-ones and remainder equal to data1, with unchanged latency.
REQ-021 Illegal fun3 (100-111) SHALL yield cdb_data 0 with cdb_valid one cycle after accept.
REQ-022 In DONE, cdb_valid, cdb_data and cdb_tag SHALL be held stable until a rising edge with cdb_ready 1, then the FSM SHALL return to IDLE.
REQ-023 cdb_valid SHALL be 0 in every state other than DONE; cdb_ready is ignored outside DONE.
REQ-024 Latched operands and tag SHALL not change while busy, regardless of data1, data2, des or issue_valid activity.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, issue_ready 1, busy 0, cdb_valid 0, cdb_data 0, cdb_tag 0, counters 0, independent of clk1.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight op without any broadcast; the first accept after rst_n rises SHALL behave as from power-up.

Configuration
REQ-027 With macro MULDIV_FLUSH_EN defined, the module SHALL add input flush (1 bit); flush high at a rising edge SHALL return the FSM to IDLE from MUL, DIV or DONE with no broadcast, and an op offered in that same cycle SHALL not be accepted.
REQ-028 Without MULDIV_FLUSH_EN, no flush port SHALL exist and only rst_n aborts an op.

Verification
REQ-029 The bench SHALL cover: defaults, data1=6, data2=7, fun3=000, des=5, cdb_ready=1 -> cdb_valid high exactly 4 cycles after accept, cdb_data=42, cdb_tag=5, issue_ready high the next cycle.
REQ-030 The bench SHALL cover: data1=100, data2=7, fun3=001, des=2 -> cdb_data=14 at accept+33 cycles; the same operands with fun3=010 -> cdb_data=2.
REQ-031 The bench SHALL cover: data1=0xFFFFFFFF, data2=0xFFFFFFFF, fun3=011 -> cdb_data=0xFFFFFFFE; data2=0 with fun3=001 -> cdb_data=0xFFFFFFFF.
REQ-032 The bench SHALL cover: cdb_ready held 0 for 10 cycles in DONE -> cdb_valid, data and tag stable throughout, and issue_valid pulses in that window are not accepted.
REQ-033 The bench SHALL cover: rst_n low at cycle 10 of a DIV -> outputs at reset values within the same cycle, no broadcast, and a new MUL completes correctly after release.
REQ-034 The bench SHALL cover: with MULDIV_FLUSH_EN, flush at cycle 2 of a MUL -> no cdb_valid, issue_ready 1 the following cycle.
